// File: rtl/result_drain_queue_if.sv
// Result/read bus between the mesh-side producer/consumer and result_drain_queue.
//   result_i       : one result row, element c = column c
//   result_valid_i : result_i holds the next row this cycle
//   read_enable_i  : request next word (row-major)
//   read_reset_i   : rewind read pointer to word 0
//   read_data_o    : registered read word
//   read_valid_o   : read_data_o valid this cycle
//   read_last_o    : accompanies the final word of the matrix
// Signal names carry the queue's point of view. The slave modport is the queue
// and the master modport is its environment.
interface result_drain_queue_if #(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [N-1:0][DATA_WIDTH-1:0] result_i;
  logic                         result_valid_i;
  logic                         read_enable_i;
  logic                         read_reset_i;
  logic [DATA_WIDTH-1:0]        read_data_o;
  logic                         read_valid_o;
  logic                         read_last_o;

  modport master (
    output result_i, result_valid_i, read_enable_i, read_reset_i,
    input  read_data_o, read_valid_o, read_last_o
  );

  modport slave (
    input  result_i, result_valid_i, read_enable_i, read_reset_i,
    output read_data_o, read_valid_o, read_last_o
  );
endinterface

// File: rtl/result_drain_queue.sv
// Result drain queue. It captures an N x N result matrix from the mesh, one row per cycle.
// It then streams the matrix out one word per read request, in row-major order, with one
// cycle of latency.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   start_i         : arm a new capture; discards buffered contents, clears overflow
//   bus             : result rows in, read requests in, read data/valid/last out
//   results_ready_o : full matrix captured, drain permitted
//   queue_empty_o   : no unread words
//   busy_o          : capture in progress
//   overflow_o      : sticky, a row arrived while draining
// N must be at least 2.
module result_drain_queue #(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  result_drain_queue_if.slave       bus,
  output logic                      results_ready_o,
  output logic                      queue_empty_o,
  output logic                      busy_o,
  output logic                      overflow_o
);

  localparam int unsigned RowCntW = $clog2(N + 1);
  localparam int unsigned RdPtrW  = $clog2(N * N + 1);
  localparam int unsigned IdxW    = $clog2(N);

  typedef enum logic [1:0] {StIdle, StCapture, StDrain} state_e;

  state_e                       state_q, state_d;
  logic [RowCntW-1:0]           row_cnt_q, row_cnt_d;
  logic [RdPtrW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]        read_data_q, read_data_d;
  logic                         read_valid_q, read_valid_d;
  logic                         read_last_q, read_last_d;
  logic                         overflow_q, overflow_d;
  logic                         mem_we;

  // One entry per row so a whole row lands in a single write.
  logic [N-1:0][DATA_WIDTH-1:0] mem_q [N];

  logic [IdxW-1:0]              wr_row;
  logic [IdxW-1:0]              rd_row;
  logic [IdxW-1:0]              rd_col;

  assign wr_row = row_cnt_q[IdxW-1:0];
  assign rd_row = IdxW'(rd_ptr_q / RdPtrW'(N));
  assign rd_col = IdxW'(rd_ptr_q % RdPtrW'(N));

  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    rd_ptr_d     = rd_ptr_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    read_last_d  = 1'b0;
    overflow_d   = overflow_q;
    mem_we       = 1'b0;

    if (start_i) begin
      // Start wins over any row or read arriving in the same cycle.
      state_d    = StCapture;
      row_cnt_d  = '0;
      rd_ptr_d   = '0;
      overflow_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StCapture: begin
          if (bus.result_valid_i) begin
            mem_we = 1'b1;
            if (row_cnt_q == RowCntW'(N - 1)) begin
              state_d   = StDrain;
              row_cnt_d = '0;
              rd_ptr_d  = '0;
            end else begin
              row_cnt_d = row_cnt_q + RowCntW'(1);
            end
          end
        end
        StDrain: begin
          if (bus.result_valid_i) overflow_d = 1'b1;
          if (bus.read_reset_i) begin
            rd_ptr_d = '0;
          end else if (bus.read_enable_i) begin
            read_data_d  = mem_q[rd_row][rd_col];
            read_valid_d = 1'b1;
            rd_ptr_d     = rd_ptr_q + RdPtrW'(1);
            if (rd_ptr_q == RdPtrW'(N * N - 1)) begin
              read_last_d = 1'b1;
              state_d     = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      row_cnt_q    <= '0;
      rd_ptr_q     <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      read_last_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      read_last_q  <= read_last_d;
      overflow_q   <= overflow_d;
    end
  end

  // Buffer storage carries no reset; contents are only meaningful after a full capture.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[wr_row] <= bus.result_i;
  end

  assign bus.read_data_o  = read_data_q;
  assign bus.read_valid_o = read_valid_q;
  assign bus.read_last_o  = read_last_q;

  assign results_ready_o = (state_q == StDrain);
  assign queue_empty_o   = (state_q != StDrain);
  assign busy_o          = (state_q == StCapture);
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_result_drain_queue.sv
module tb_result_drain_queue;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic results_ready;
  logic queue_empty;
  logic busy;
  logic overflow;

  int n_cmp = 0;
  int n_bad = 0;

  result_drain_queue_if #(.N(N), .DATA_WIDTH(DW)) bus ();

  result_drain_queue #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .bus             (bus),
    .results_ready_o (results_ready),
    .queue_empty_o   (queue_empty),
    .busy_o          (busy),
    .overflow_o      (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".data"},     bus.read_data_o,  0);
    check_eq({tag, ".valid"},    bus.read_valid_o, 0);
    check_eq({tag, ".last"},     bus.read_last_o,  0);
    check_eq({tag, ".ready"},    results_ready,    0);
    check_eq({tag, ".empty"},    queue_empty,      1);
    check_eq({tag, ".busy"},     busy,             0);
    check_eq({tag, ".overflow"}, overflow,         0);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic capture_rows(input int base, input int rows);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < N; c++) bus.result_i[c] = 32'(base + r * N + c);
      bus.result_valid_i = 1'b1;
      step();
    end
    bus.result_valid_i = 1'b0;
  endtask

  // Reads held back to back; word i must equal base+i.
  task automatic burst_read(input string tag, input int base, input int first, input int count);
    bus.read_enable_i = 1'b1;
    for (int i = first; i < first + count; i++) begin
      step();
      check_eq({tag, ".valid"}, bus.read_valid_o, 1);
      check_eq({tag, ".data"},  bus.read_data_o,  32'(base + i));
      check_eq({tag, ".last"},  bus.read_last_o,  (i == N * N - 1) ? 1 : 0);
    end
    bus.read_enable_i = 1'b0;
  endtask

  initial begin
    rst                = 1'b1;
    start              = 1'b0;
    bus.result_i       = '0;
    bus.result_valid_i = 1'b0;
    bus.read_enable_i  = 1'b0;
    bus.read_reset_i   = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    check_reset_outputs("reset");

    // Basic capture then spaced single reads.
    do_start();
    check_eq("start.busy", busy, 1);
    check_eq("start.empty", queue_empty, 1);
    capture_rows(0, N);
    check_eq("cap.ready", results_ready, 1);
    check_eq("cap.busy", busy, 0);
    check_eq("cap.empty", queue_empty, 0);
    for (int i = 0; i < N * N; i++) begin
      bus.read_enable_i = 1'b1;
      step();
      bus.read_enable_i = 1'b0;
      check_eq("single.valid", bus.read_valid_o, 1);
      check_eq("single.data", bus.read_data_o, 32'(i));
      check_eq("single.last", bus.read_last_o, (i == N * N - 1) ? 1 : 0);
      step();
      check_eq("single.gap_valid", bus.read_valid_o, 0);
    end
    check_eq("single.done_empty", queue_empty, 1);
    check_eq("single.done_ready", results_ready, 0);

    // Back-to-back drain.
    do_start();
    capture_rows(100, N);
    burst_read("b2b", 100, 0, N * N);
    step();
    check_eq("b2b.after_valid", bus.read_valid_o, 0);
    check_eq("b2b.after_empty", queue_empty, 1);

    // Read request in IDLE is ignored and data holds.
    bus.read_enable_i = 1'b1;
    step();
    bus.read_enable_i = 1'b0;
    check_eq("idle_rd.valid", bus.read_valid_o, 0);
    check_eq("idle_rd.data", bus.read_data_o, 115);

    // Rewind: read 0..5, rewind with enable, read again from 0.
    do_start();
    capture_rows(200, N);
    burst_read("pre_rw", 200, 0, 6);
    bus.read_reset_i  = 1'b1;
    bus.read_enable_i = 1'b1;
    step();
    bus.read_reset_i  = 1'b0;
    bus.read_enable_i = 1'b0;
    check_eq("rewind.valid", bus.read_valid_o, 0);
    burst_read("post_rw", 200, 0, 3);

    // Row during drain sets overflow and leaves the buffer untouched.
    for (int c = 0; c < N; c++) bus.result_i[c] = 32'(900 + c);
    bus.result_valid_i = 1'b1;
    step();
    bus.result_valid_i = 1'b0;
    check_eq("ovf.set", overflow, 1);
    check_eq("ovf.ready", results_ready, 1);
    burst_read("ovf.data", 200, 3, 2);
    check_eq("ovf.sticky", overflow, 1);
    do_start();
    check_eq("ovf.cleared", overflow, 0);
    check_eq("ovf.busy", busy, 1);

    // Abort after two rows. The restart cycle's row is dropped.
    capture_rows(300, 2);
    check_eq("abort.busy", busy, 1);
    for (int c = 0; c < N; c++) bus.result_i[c] = 32'(999);
    bus.result_valid_i = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    bus.result_valid_i = 1'b0;
    check_eq("abort.restart_busy", busy, 1);
    capture_rows(400, 3);
    check_eq("abort.not_ready", results_ready, 0);
    capture_rows(400 + 3 * N, 1);
    check_eq("abort.ready", results_ready, 1);
    burst_read("abort", 400, 0, N * N);

    // Reset during drain at word 7.
    do_start();
    capture_rows(500, N);
    bus.result_valid_i = 1'b1;
    step();
    bus.result_valid_i = 1'b0;
    check_eq("mid_rst.ovf_pre", overflow, 1);
    burst_read("mid_rst.pre", 500, 0, 7);
    bus.read_enable_i = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.read_enable_i = 1'b0;
    check_reset_outputs("mid_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
